// File: rtl/cnn_pkg.sv
// Shared widths, shift-amount width and signed sample types for the upscaling datapath.
package cnn_pkg;
  localparam int IN_RES    = 8;
  localparam int OUT_RES   = 32;
  localparam int SCALE_RES = 16;
  localparam int SHIFT_W   = 4;

  typedef logic signed [IN_RES-1:0]    int8_t;
  typedef logic signed [OUT_RES-1:0]   int32_t;
  typedef logic signed [SCALE_RES-1:0] scale_t;
endpackage

// File: rtl/upscaling_sat_shift.sv
// Combinational left shift of the stage-1 product to the output width; clamps when
// UPSCALING_SAT_EN is defined, otherwise keeps the low output bits (wrap).
module upscaling_sat_shift
  import cnn_pkg::*;
#(
  parameter int PROD_W = IN_RES + 1 + SCALE_RES,
  parameter int OUT_W  = OUT_RES
) (
  input  logic signed [PROD_W-1:0]  i_p,
  input  logic        [SHIFT_W-1:0] i_n,
  output logic signed [OUT_W-1:0]   o_dat,
  output logic                      o_sat
);

`ifdef UPSCALING_SAT_EN
  // Wide enough that the maximum shift never drops a bit.
  localparam int R_W = PROD_W + (1 << SHIFT_W) - 1;

  logic signed [R_W-1:0]     w_r;
  logic        [R_W-OUT_W:0] w_hi;

  always_comb begin
    w_r   = {{(R_W-PROD_W){i_p[PROD_W-1]}}, i_p} <<< i_n;
    w_hi  = w_r[R_W-1:OUT_W-1];
    o_dat = w_r[OUT_W-1:0];
    o_sat = 1'b0;
    // Representable only if every bit above the output sign bit matches it.
    if (!(&w_hi) && (|w_hi)) begin
      o_sat = 1'b1;
      o_dat = w_r[R_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic signed [OUT_W-1:0] w_p_ext;

  assign w_p_ext = {{(OUT_W-PROD_W){i_p[PROD_W-1]}}, i_p};
  assign o_dat   = w_p_ext <<< i_n;
  assign o_sat   = 1'b0;
`endif

endmodule

// File: rtl/int8_to_int32_in.sv
// Int8 -> int32 upscaling, 2-stage valid/ready pipeline: ((data-zp)*scale) <<< n.
// Latency 2 cycles, 1 beat/cycle; UPSCALING_SAT_EN selects clamping instead of wrap.
module int8_to_int32_in
  import cnn_pkg::*;
#(
  parameter int UPSCALING_IN_RESOLUTION    = IN_RES,
  parameter int UPSCALING_OUT_RESOLUTION   = OUT_RES,
  parameter int UPSCALING_SCALE_RESOLUTION = SCALE_RES
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic signed [UPSCALING_IN_RESOLUTION-1:0]    upscaling_zp_i,
  input  logic signed [UPSCALING_SCALE_RESOLUTION-1:0] upscaling_scale_i,
  input  logic        [SHIFT_W-1:0]                    upscaling_n_i,
  input  logic                                         upscaling_valid_i,
  input  logic signed [UPSCALING_IN_RESOLUTION-1:0]    upscaling_data_i,
  output logic                                         upscaling_ready_o,
  output logic                                         upscaling_valid_o,
  output logic signed [UPSCALING_OUT_RESOLUTION-1:0]   upscaling_data_o,
  input  logic                                         upscaling_ready_i,
  output logic                                         upscaling_sat_o
);

  localparam int D_W    = UPSCALING_IN_RESOLUTION + 1;
  localparam int PROD_W = D_W + UPSCALING_SCALE_RESOLUTION;

  logic signed [D_W-1:0]                      w_d;
  logic signed [PROD_W-1:0]                   w_p;
  logic                                       w_accept;
  logic                                       w_s2_load;
  logic signed [UPSCALING_OUT_RESOLUTION-1:0] w_s2_dat;
  logic                                       w_s2_sat;

  logic                                       r_s1_vld;
  logic signed [PROD_W-1:0]                   r_s1_p;
  logic        [SHIFT_W-1:0]                  r_s1_n;
  logic                                       r_s2_vld;
  logic signed [UPSCALING_OUT_RESOLUTION-1:0] r_s2_dat;
  logic                                       r_s2_sat;

  // One extra bit keeps data - zp exact over the full signed input range.
  assign w_d = {upscaling_data_i[UPSCALING_IN_RESOLUTION-1], upscaling_data_i}
             - {upscaling_zp_i[UPSCALING_IN_RESOLUTION-1], upscaling_zp_i};
  assign w_p = w_d * upscaling_scale_i;

  assign w_s2_load         = r_s1_vld && (!r_s2_vld || upscaling_ready_i);
  assign upscaling_ready_o = !r_s1_vld || w_s2_load;
  assign w_accept          = upscaling_valid_i && upscaling_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_vld <= 1'b0;
      r_s1_p   <= '0;
      r_s1_n   <= '0;
    end else if (w_accept) begin
      r_s1_vld <= 1'b1;
      r_s1_p   <= w_p;
      r_s1_n   <= upscaling_n_i;
    end else if (w_s2_load) begin
      r_s1_vld <= 1'b0;
    end
  end

  upscaling_sat_shift #(
    .PROD_W (PROD_W),
    .OUT_W  (UPSCALING_OUT_RESOLUTION)
  ) u_sat_shift (
    .i_p   (r_s1_p),
    .i_n   (r_s1_n),
    .o_dat (w_s2_dat),
    .o_sat (w_s2_sat)
  );

  // Output registers only change on a load, so they hold during a stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
      r_s2_sat <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_vld <= 1'b1;
      r_s2_dat <= w_s2_dat;
      r_s2_sat <= w_s2_sat;
    end else if (upscaling_ready_i) begin
      r_s2_vld <= 1'b0;
    end
  end

  assign upscaling_valid_o = r_s2_vld;
  assign upscaling_data_o  = r_s2_dat;
  assign upscaling_sat_o   = r_s2_sat;

endmodule

// File: tb/tb_int8_to_int32_in.sv
// Bench for int8_to_int32_in: vector table, stall/reset sequences, random stream vs arithmetic model.
module tb_int8_to_int32_in;
  import cnn_pkg::*;

  typedef struct {
    int8_t        zp;
    scale_t       sc;
    logic [3:0]   n;
    int8_t        dat;
  } beat_t;

  typedef struct {
    int dat;
    bit sat;
  } exp_t;

  typedef struct {
    beat_t b;
    exp_t  e;
  } vec_t;

`ifdef UPSCALING_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni;
  int8_t      zp_i;
  scale_t     scale_i;
  logic [3:0] n_i;
  logic       valid_i;
  int8_t      data_i;
  logic       ready_o;
  logic       valid_o;
  int32_t     data_o;
  logic       ready_i;
  logic       sat_o;

  int8_to_int32_in dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .upscaling_zp_i    (zp_i),
    .upscaling_scale_i (scale_i),
    .upscaling_n_i     (n_i),
    .upscaling_valid_i (valid_i),
    .upscaling_data_i  (data_i),
    .upscaling_ready_o (ready_o),
    .upscaling_valid_o (valid_o),
    .upscaling_data_o  (data_o),
    .upscaling_ready_i (ready_i),
    .upscaling_sat_o   (sat_o)
  );

  always #5 clk_i = ~clk_i;

  int     n_chk = 0;
  int     n_pass = 0;
  exp_t   exp_q[$];
  int     got_q[$];
  bit     prev_stall = 1'b0;
  int32_t prev_dat;
  logic   prev_sat;
  bit     last_in_fire;
  beat_t  cur_b;
  vec_t   tbl[9];

  // Reference: exact integer arithmetic, then clamp or wrap to 32 bits.
  function automatic exp_t model(beat_t b);
    longint r;
    exp_t   e;
    r = (longint'(b.dat) - longint'(b.zp)) * longint'(b.sc) * (longint'(1) << b.n);
    e.dat = int'(r);
    e.sat = 1'b0;
    if (SAT && r > 64'sd2147483647) begin
      e.dat = 32'sh7fffffff;
      e.sat = 1'b1;
    end else if (SAT && r < -64'sd2147483648) begin
      e.dat = 32'sh80000000;
      e.sat = 1'b1;
    end
    return e;
  endfunction

  function automatic beat_t mkb(int zp, int sc, int n, int d);
    beat_t b;
    b.zp  = 8'(zp);
    b.sc  = 16'(sc);
    b.n   = 4'(n);
    b.dat = 8'(d);
    return b;
  endfunction

  function automatic vec_t mk(int zp, int sc, int n, int d, int e, bit s);
    vec_t v;
    v.b     = mkb(zp, sc, n, d);
    v.e.dat = e;
    v.e.sat = s;
    return v;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.zp  = 8'($urandom);
    b.sc  = 16'($urandom);
    b.n   = 4'($urandom);
    b.dat = 8'($urandom);
    return b;
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  task automatic drive(input bit v, input beat_t b, input bit rdy);
    valid_i = v;
    zp_i    = b.zp;
    scale_i = b.sc;
    n_i     = b.n;
    data_i  = b.dat;
    ready_i = rdy;
    cur_b   = b;
  endtask

  // One clock with scoreboard bookkeeping; inputs are set before calling, at a negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (prev_stall) begin
      chk("stall_hold_vld", valid_o, 1);
      chk("stall_hold_dat", data_o, prev_dat);
      chk("stall_hold_sat", sat_o, prev_sat);
    end
    last_in_fire = valid_i && ready_o;
    if (valid_o && ready_i) begin
      got_q.push_back(data_o);
      if (exp_q.size() == 0) chk("unexpected_beat_vld", valid_o, 0);
      else begin
        e = exp_q.pop_front();
        chk("beat_dat", data_o, e.dat);
        chk("beat_sat", sat_o, e.sat);
      end
    end
    if (last_in_fire) exp_q.push_back(model(cur_b));
    prev_stall = valid_o && !ready_i;
    prev_dat   = data_o;
    prev_sat   = sat_o;
    @(negedge clk_i);
  endtask

  initial begin
    beat_t b;
    beat_t rb;
    bit    have;
    int    sent;
    int    cyc;

    tbl[0] = mk(0, 1, 0, -128, -128, 1'b0);
    tbl[1] = mk(-28, 16384, 7, 100, 268435456, 1'b0);
    tbl[2] = mk(-28, 32767, 15, 100, SAT ? 32'sh7fffffff : -4194304, SAT);
    tbl[3] = mk(127, 32767, 15, -128, SAT ? 32'sh80000000 : 1082097664, SAT);
    tbl[4] = mk(5, -700, 3, 5, 0, 1'b0);
    tbl[5] = mk(-128, -32768, 0, 127, -8355840, 1'b0);
    tbl[6] = mk(-128, -32768, 15, 127, SAT ? 32'sh80000000 : 1073741824, SAT);
    tbl[7] = mk(0, 16384, 15, 4, SAT ? 32'sh7fffffff : 32'sh80000000, SAT);
    tbl[8] = mk(0, 16384, 15, -4, 32'sh80000000, 1'b0);

    rst_ni = 1'b0;
    drive(1'b0, mkb(0, 0, 0, 0), 1'b1);
    repeat (2) @(negedge clk_i);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_sat_o", sat_o, 0);
    chk("rst_ready_o", ready_o, 1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tbl[i].b, 1'b1);
      tick();
      chk($sformatf("vec%0d_accept", i), last_in_fire, 1);
      drive(1'b0, tbl[i].b, 1'b1);
      chk($sformatf("vec%0d_vld_c1", i), valid_o, 0);
      tick();
      chk($sformatf("vec%0d_vld_c2", i), valid_o, 1);
      chk($sformatf("vec%0d_dat", i), data_o, tbl[i].e.dat);
      chk($sformatf("vec%0d_sat", i), sat_o, tbl[i].e.sat);
      tick();
    end

    // Three beats into a stalled output: two fit, the third is held off.
    got_q.delete();
    drive(1'b1, mkb(0, 1, 0, 1), 1'b0);
    #1 chk("stall_rdy_b1", ready_o, 1);
    tick();
    drive(1'b1, mkb(0, 1, 0, 2), 1'b0);
    #1 chk("stall_rdy_b2", ready_o, 1);
    tick();
    drive(1'b1, mkb(0, 1, 0, 3), 1'b0);
    #1 chk("stall_rdy_b3", ready_o, 0);
    chk("stall_vld", valid_o, 1);
    chk("stall_dat", data_o, 1);
    repeat (3) tick();
    drive(1'b1, mkb(0, 1, 0, 3), 1'b1);
    tick();
    chk("stall_b3_accept", last_in_fire, 1);
    drive(1'b0, mkb(0, 1, 0, 3), 1'b1);
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) tick();
    chk("stall_drained", exp_q.size(), 0);
    chk("stall_out_count", got_q.size(), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("stall_order%0d", k), got_q[k], k + 1);

    // Reset with both stages full.
    drive(1'b1, mkb(0, 1, 0, 11), 1'b0);
    tick();
    drive(1'b1, mkb(0, 1, 0, 12), 1'b0);
    tick();
    drive(1'b0, mkb(0, 1, 0, 12), 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_valid_o", valid_o, 0);
    chk("midrst_data_o", data_o, 0);
    chk("midrst_sat_o", sat_o, 0);
    chk("midrst_ready_o", ready_o, 1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b0, mkb(0, 1, 0, 0), 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("postrst_idle%0d", k), valid_o, 0);
    end
    drive(1'b1, mkb(3, -5, 2, 7), 1'b1);
    tick();
    drive(1'b0, mkb(0, 1, 0, 0), 1'b1);
    chk("postrst_vld_c1", valid_o, 0);
    tick();
    chk("postrst_vld_c2", valid_o, 1);
    chk("postrst_dat", data_o, -80);
    tick();

    // Random stream with random downstream backpressure.
    have = 1'b0;
    sent = 0;
    cyc  = 0;
    rb   = rand_beat();
    while (sent < 5000 && cyc < 40000) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        rb   = rand_beat();
        have = 1'b1;
      end
      b = have ? rb : rand_beat();
      drive(have, b, $urandom_range(0, 3) != 0);
      tick();
      if (last_in_fire) begin
        have = 1'b0;
        sent++;
      end
      cyc++;
    end
    chk("rand_sent", sent, 5000);
    drive(1'b0, mkb(0, 0, 0, 0), 1'b1);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    chk("rand_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/int8_to_int32_in.md
INT8_TO_INT32_IN -- requirements
Module: int8_to_int32_in

Interface
REQ-001 SHALL have parameter UPSCALING_IN_RESOLUTION, default 8, input sample width (signed).
REQ-002 SHALL have parameter UPSCALING_OUT_RESOLUTION, default 32, output sample width (signed).
REQ-003 SHALL have parameter UPSCALING_SCALE_RESOLUTION, default 16, signed scale multiplier width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port upscaling_zp_i  input  IN_RES  signed input zero point.
REQ-007 SHALL have port upscaling_scale_i  input  SCALE_RES  signed multiplier.
REQ-008 SHALL have port upscaling_n_i  input  4  left-shift amount, 0..15.
REQ-009 SHALL have port upscaling_valid_i  input  1  input beat valid.
REQ-010 SHALL have port upscaling_data_i  input  IN_RES  signed int8 sample.
REQ-011 SHALL have port upscaling_ready_o  output  1  block can accept a beat.
REQ-012 SHALL have port upscaling_valid_o  output  1  output beat valid.
REQ-013 SHALL have port upscaling_data_o  output  OUT_RES  signed int32 result.
REQ-014 SHALL have port upscaling_ready_i  input  1  downstream accepts a beat.
REQ-015 SHALL have port upscaling_sat_o  output  1  current output beat was saturated.

Function
REQ-016 SHALL compute, per beat: d = data - zp (IN_RES+1 bits signed); p = d * scale (signed, full width); r = p <<< n (full width, no bit loss).
REQ-017 SHALL produce upscaling_data_o = r clamped to [-2^31, 2^31-1] (macro on) or low OUT_RES bits of r (macro off).
REQ-018 SHALL accept a beat on a cycle where upscaling_valid_i && upscaling_ready_o.
REQ-019 SHALL sample zp, scale and n together with data at acceptance and carry n with the beat; later config changes SHALL NOT affect in-flight beats.
REQ-020 SHALL be a 2-stage pipeline: stage 1 registers p and n; stage 2 registers shifted/saturated result and sat flag.
REQ-021 SHALL deliver a beat on upscaling_valid_o exactly 2 cycles after acceptance when upscaling_ready_i is held high.
REQ-022 SHALL sustain 1 beat/cycle throughput with upscaling_ready_i high.
REQ-023 SHALL hold upscaling_data_o, upscaling_sat_o stable while valid_o && !ready_i.
REQ-024 SHALL advance a stage only if next stage is empty or being drained the same cycle; upscaling_ready_o = !s1_valid || stage-1 advancing.
REQ-025 SHALL allow simultaneous accept and output-drain in one cycle without beat loss or duplication.
REQ-026 SHALL preserve beat order; at most 2 beats in flight.
REQ-027 SHALL treat n values as unsigned 0..15; no other range exists.

Reset
REQ-028 SHALL, while rst_ni low, force both stage valids 0, upscaling_valid_o 0, upscaling_data_o 0, upscaling_sat_o 0, upscaling_ready_o 1 after reset release.
REQ-029 SHALL discard all in-flight beats on reset asserted mid-operation; first beat after release follows REQ-021.

Configuration
REQ-030 SHALL honour macro UPSCALING_SAT_EN: defined -> clamp per REQ-017 and upscaling_sat_o=1 when clamped; undefined -> wrap, upscaling_sat_o tied 0, no comparator logic.

Structure
REQ-031 SHALL take widths, shift-width constant and signed sample typedefs (int8, int32, scale) from shared package cnn_pkg.
REQ-032 SHALL place the stage-2 shift+saturate logic in sub-module upscaling_sat_shift (combinational, parameterised by widths).

Verification
REQ-033 zp=0, scale=1, n=0, data=-128 one beat -> data_o=-128, valid_o 2 cycles later, sat_o=0.
REQ-034 zp=-28, scale=16384, n=7, data=100 -> data_o=268435456, sat_o=0.
REQ-035 zp=-28, scale=32767, n=15, data=100 -> macro on: 2147483647, sat_o=1; macro off: -4194304 (0xFFC00000), sat_o=0.
REQ-036 zp=127, scale=32767, n=15, data=-128 -> macro on: -2147483648, sat_o=1.
REQ-037 ready_i=0, drive 3 consecutive beats (1,2,3; zp=0, scale=1, n=0) -> 2 accepted, ready_o=0 on third; release ready_i -> outputs 1,2,3 in order, data stable during stall.
REQ-038 Assert rst_ni low with 2 beats in flight -> valid_o=0 immediately, no stale beat after release; 5000-beat random stream with random ready_i matches golden model.
